wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Round-robin arbiter for the single register-file write port of the pipelined CPU. Four writeback sources (ALU, load unit, multiply/divide unit, CP0 read) compete for the port; the block grants one per cycle. It drives the 2-bit select of the external 4:1 destination-address mux and registers the winning address/data into a one-stage writeback register feeding the register file.

## Interface
- `DW`, default 32: writeback data width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  4  per-source write request; bit i = source i.
- `req_addr`  in  4×5 (20, packed, source i at [5i+4:5i])  destination register per source.
- `req_data`  in  4×DW (packed, same ordering)  write data per source.
- `req_ready`  out  4  one-hot grant; source i's request is accepted when `req_valid[i] & req_ready[i]`.
- `wb_stall`  in  1  register-file port unavailable this cycle (e.g. cache miss freeze).
- `addr_sel`  out  2  combinational index of the current grant; drives the external address-mux select.
- `wb_we`  out  1  registered write enable to the register file.
- `wb_addr`  out  5  registered write address.
- `wb_data`  out  DW  registered write data.
- `wb_src`  out  2  registered index of the source that produced the current write.

## Operation
- Priority pointer `ptr` (2 bits) names the highest-priority source. Search order: ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- Grant: first source in search order with `req_valid` set, only when `wb_stall`=0. At most one `req_ready` bit high; all zero when no request or `wb_stall`=1.
- `addr_sel` = index of the granted source; holds its previous value when nothing is granted.
- On an accepted request from source g: `wb_addr`←addr, `wb_data`←data, `wb_src`←g, `wb_we`←(addr≠0), `ptr`←g+1 mod 4.
- Register 0 is hardwired zero: a request to address 0 completes its handshake and advances `ptr`, but `wb_we` stays 0.
- No request and `wb_stall`=0: `wb_we`←0; `wb_addr`/`wb_data`/`wb_src`/`ptr` hold.
- `wb_stall`=1: every output register and `ptr` hold, including `wb_we` (the pending write stays presented until the stall clears).
- Requests are level-held by the sources until accepted; the arbiter does not buffer unaccepted requests.

## Timing
- Grant path (`req_valid`,`wb_stall`,`ptr` → `req_ready`,`addr_sel`) is combinational, same cycle.
- Write latency: request accepted in cycle N → `wb_we`/`wb_addr`/`wb_data` valid in cycle N+1.
- Throughput: one accepted write per non-stalled cycle. With all four requests held continuously, each source is granted once every 4 cycles (starvation-free).
- Reset: `ptr`=0, `wb_we`=0, `wb_addr`=0, `wb_data`=0, `wb_src`=0, `addr_sel`=0. Reset overrides `wb_stall`. A write registered in the reset cycle is dropped.
- Simultaneous `req_valid` change and grant: the grant uses the current cycle's `req_valid`; a source that drops a request in the same cycle is not granted.

## Structure
- Shared package `wb_pkg`: `NSRC`=4, `RAW`=5 (register address width), source indices `SRC_ALU`=0, `SRC_MEM`=1, `SRC_MDU`=2, `SRC_CP0`=3.
- One sub-module: `rr_arb4`, purely combinational. Inputs: 4-bit request, 2-bit pointer, enable. Outputs: one-hot grant, 2-bit index, any-grant flag. The top level holds `ptr` and the writeback register.

## Test plan
- Reset, then `req_valid`=0001, addr 8, data 0xDEADBEEF → `req_ready`=0001 and `addr_sel`=0 that cycle; next cycle `wb_we`=1, `wb_addr`=8, `wb_data`=0xDEADBEEF, `wb_src`=0, `ptr`=1.
- All four requests held for 8 cycles (addrs 1,2,3,4) from `ptr`=0 → grants 0,1,2,3,0,1,2,3; `wb_addr` sequence 1,2,3,4,1,2,3,4.
- `ptr`=2, `req_valid`=1011 → grant source 3, then `ptr`=0. Next grant is source 0 while 1011 is still held.
- Source 1 requests addr 0 → handshake completes and `ptr` advances, but `wb_we`=0.
- Accept a write to addr 5, then assert `wb_stall` for 3 cycles with requests pending → `req_ready`=0000; `wb_we`=1 and `wb_addr`=5 hold; after the stall clears, the next grant follows `ptr`.
- Assert `rst` in the cycle after an accept → next cycle all outputs are 0 and `ptr`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-port arbiter: source count, register
// address width, source indices and the round-robin pointer step.
package wb_pkg;

  localparam int NSRC = 4;
  localparam int RAW  = 5;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_MEM = 2'd1;
  localparam src_idx_t SRC_MDU = 2'd2;
  localparam src_idx_t SRC_CP0 = 2'd3;

  // The winner drops to lowest priority; the pointer wraps modulo 4.
  function automatic src_idx_t next_ptr(input src_idx_t g);
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: searches ptr, ptr+1, ptr+2, ptr+3
// and returns the first active request as one-hot grant plus index.
module rr_arb4
  import wb_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  src_idx_t        ptr,
  input  logic            en,
  output logic [NSRC-1:0] grant,
  output src_idx_t        idx,
  output logic            any
);

  src_idx_t cand_s;

  // Walk the search order from lowest to highest priority so the last hit wins.
  always_comb begin
    grant  = 4'b0000;
    idx    = 2'd0;
    any    = 1'b0;
    cand_s = 2'd0;
    if (en) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        cand_s = ptr + 2'(k);
        if (req[cand_s]) begin
          idx = cand_s;
          any = 1'b1;
        end else begin
          any = any;
        end
      end
      if (any) begin
        grant = 4'b0001 << idx;
      end else begin
        grant = 4'b0000;
      end
    end else begin
      grant = 4'b0000;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port: grants one writeback
// source per unstalled cycle and registers its address/data for the regfile.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      req_valid,
  input  logic [NSRC*RAW-1:0]  req_addr,
  input  logic [NSRC*DW-1:0]   req_data,
  output logic [NSRC-1:0]      req_ready,
  input  logic                 wb_stall,
  output logic [1:0]           addr_sel,
  output logic                 wb_we,
  output logic [RAW-1:0]       wb_addr,
  output logic [DW-1:0]        wb_data,
  output logic [1:0]           wb_src
);

  src_idx_t            ptr_r;
  src_idx_t            last_sel_r;
  logic                wb_we_r;
  logic [RAW-1:0]      wb_addr_r;
  logic [DW-1:0]       wb_data_r;
  src_idx_t            wb_src_r;

  logic [NSRC-1:0]     grant_s;
  src_idx_t            idx_s;
  logic                any_s;
  logic [RAW-1:0]      sel_addr_s;
  logic [DW-1:0]       sel_data_s;

  rr_arb4 u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .en    (~wb_stall),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  assign req_ready = grant_s;

  // Address-mux select follows the live grant and parks on the last winner.
  always_comb begin
    addr_sel = last_sel_r;
    if (any_s) begin
      addr_sel = idx_s;
    end else begin
      addr_sel = last_sel_r;
    end
  end

  // Route the granted source's address and data toward the writeback register.
  always_comb begin
    sel_addr_s = {RAW{1'b0}};
    sel_data_s = {DW{1'b0}};
    case (idx_s)
      SRC_ALU: begin
        sel_addr_s = req_addr[0*RAW +: RAW];
        sel_data_s = req_data[0*DW +: DW];
      end
      SRC_MEM: begin
        sel_addr_s = req_addr[1*RAW +: RAW];
        sel_data_s = req_data[1*DW +: DW];
      end
      SRC_MDU: begin
        sel_addr_s = req_addr[2*RAW +: RAW];
        sel_data_s = req_data[2*DW +: DW];
      end
      SRC_CP0: begin
        sel_addr_s = req_addr[3*RAW +: RAW];
        sel_data_s = req_data[3*DW +: DW];
      end
      default: begin
        sel_addr_s = {RAW{1'b0}};
        sel_data_s = {DW{1'b0}};
      end
    endcase
  end

  // Pointer and writeback stage; a stall freezes everything, including wb_we,
  // so the pending write stays presented. Writes to r0 complete but never enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= 2'd0;
      last_sel_r <= 2'd0;
      wb_we_r    <= 1'b0;
      wb_addr_r  <= {RAW{1'b0}};
      wb_data_r  <= {DW{1'b0}};
      wb_src_r   <= 2'd0;
    end else if (any_s) begin
      ptr_r      <= next_ptr(idx_s);
      last_sel_r <= idx_s;
      wb_we_r    <= (sel_addr_s != {RAW{1'b0}});
      wb_addr_r  <= sel_addr_s;
      wb_data_r  <= sel_data_s;
      wb_src_r   <= idx_s;
    end else if (!wb_stall) begin
      wb_we_r    <= 1'b0;
    end else begin
      wb_we_r    <= wb_we_r;
    end
  end

  assign wb_we   = wb_we_r;
  assign wb_addr = wb_addr_r;
  assign wb_data = wb_data_r;
  assign wb_src  = wb_src_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural round-robin model.
module tb_wb_port_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [19:0]     req_addr;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            wb_stall;
  logic [1:0]      addr_sel;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [DW-1:0]   wb_data;
  logic [1:0]      wb_src;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .addr_sel  (addr_sel),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_src    (wb_src)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Per-source stimulus values, packed onto the buses each cycle.
  logic [4:0]    sa [4];
  logic [DW-1:0] sd [4];

  // Reference model state.
  int            m_ptr;
  int            m_last;
  logic          m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  int            m_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_last = 0;
    m_we   = 1'b0;
    m_addr = 5'd0;
    m_data = '0;
    m_src  = 0;
  endtask

  // One clock: drive, check grant mid-cycle, clock, check the writeback stage.
  task automatic cyc(input logic [3:0] v, input logic st, input logic r);
    int g;
    g = -1;
    req_valid = v;
    wb_stall  = st;
    rst       = r;
    for (int i = 0; i < 4; i++) begin
      req_addr[5*i +: 5]   = sa[i];
      req_data[DW*i +: DW] = sd[i];
    end
    if (!st) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    #2;
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("addr_sel", 64'(addr_sel), (g < 0) ? 64'(m_last) : 64'(g));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (st) begin
      m_we = m_we;
    end else if (g >= 0) begin
      m_addr = sa[g];
      m_data = sd[g];
      m_src  = g;
      m_we   = (sa[g] != 5'd0);
      m_ptr  = (g + 1) % 4;
      m_last = g;
    end else begin
      m_we = 1'b0;
    end
    #1;
    chk("wb_we", 64'(wb_we), 64'(m_we));
    chk("wb_addr", 64'(wb_addr), 64'(m_addr));
    chk("wb_data", 64'(wb_data), 64'(m_data));
    chk("wb_src", 64'(wb_src), 64'(m_src));
  endtask

  initial begin
    rst       = 1'b1;
    wb_stall  = 1'b0;
    req_valid = 4'b0000;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      sa[i] = 5'd0;
      sd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cyc(4'b0000, 1'b0, 1'b1);

    // Single ALU write to r8.
    sa[0] = 5'd8;
    sd[0] = 32'hDEADBEEF;
    cyc(4'b0001, 1'b0, 1'b0);
    chk("first_addr", 64'(wb_addr), 64'd8);
    chk("first_data", 64'(wb_data), 64'hDEADBEEF);
    chk("first_we", 64'(wb_we), 64'd1);

    // Bring ptr back to 0, then all four held for 8 cycles.
    for (int i = 0; i < 4; i++) begin
      sa[i] = 5'(i + 1);
      sd[i] = 32'h1000_0000 + 32'(i);
    end
    cyc(4'b1000, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      chk("rr_addr", 64'(wb_addr), 64'((n % 4) + 1));
    end

    // ptr=2 with 1011 held: source 3 then source 0.
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b1011, 1'b0, 1'b0);
    chk("wrap_src3", 64'(wb_src), 64'd3);
    cyc(4'b1011, 1'b0, 1'b0);
    chk("wrap_src0", 64'(wb_src), 64'd0);

    // Write to r0 from source 1: handshake, no enable.
    sa[1] = 5'd0;
    cyc(4'b0010, 1'b0, 1'b0);
    chk("r0_we", 64'(wb_we), 64'd0);
    cyc(4'b0110, 1'b0, 1'b0);
    chk("r0_ptr_adv", 64'(wb_src), 64'd2);

    // Write r5, stall three cycles with requests pending, then resume.
    sa[0] = 5'd5;
    cyc(4'b0001, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk("stall_we", 64'(wb_we), 64'd1);
      chk("stall_addr", 64'(wb_addr), 64'd5);
    end
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Reset right after an accept.
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_addr", 64'(wb_addr), 64'd0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("rst_ptr0", 64'(wb_src), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        sa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        sd[i] = 32'($urandom);
      end
      cyc(4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
